// File: rtl/lzc_norm_pipe_pkg.sv
// fpu_lzc_pkg: shared definitions for the pipelined leading/trailing-zero
// counter and normaliser.
//   MAX_XLEN          widest supported datapath
//   DEF_XLEN/DEF_XLOG default datapath and count widths
//   TAG_W             sideband tag width
//   lzc_beat_t        one result beat at the default width
//   bit_reverse()     full-width bit reversal
//   levels_in_stage() number of shift levels placed in a register stage
//   stage_first_level() index of the first shift level of a stage
package fpu_lzc_pkg;

  localparam int MAX_XLEN = 256;
  localparam int DEF_XLEN = 64;
  localparam int DEF_XLOG = $clog2(DEF_XLEN);
  localparam int TAG_W    = 8;

  typedef struct packed {
    logic [DEF_XLEN-1:0] norm;
    logic [DEF_XLOG-1:0] count;
    logic                zero;
    logic                mode;
    logic [TAG_W-1:0]    tag;
  } lzc_beat_t;

  // Reverses all MAX_XLEN bits. A narrower operand is reversed by first
  // left-aligning it in the MAX_XLEN word and keeping the low bits of the result.
  function automatic logic [MAX_XLEN-1:0] bit_reverse(input logic [MAX_XLEN-1:0] value);
    logic [MAX_XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_XLEN; i++) begin
      r[i] = value[MAX_XLEN-1-i];
    end
    return r;
  endfunction

  // Levels are split evenly; the remainder goes to the earliest stages.
  function automatic int levels_in_stage(input int stage, input int xlog, input int stages);
    return (xlog / stages) + ((stage < (xlog % stages)) ? 1 : 0);
  endfunction

  // Shift levels are numbered 0 (2^(XLOG-1) shift) up to XLOG-1 (shift by 1).
  function automatic int stage_first_level(input int stage, input int xlog, input int stages);
    int acc;
    acc = 0;
    for (int j = 0; j < stage; j++) begin
      acc = acc + levels_in_stage(j, xlog, stages);
    end
    return acc;
  endfunction

endpackage

// File: rtl/lzc_norm_pipe_level.sv
// lzc_norm_level: one combinational shift level of the zero counter.
// If the top 2^K bits of value_in are all zero the value is shifted left by
// 2^K and count bit K is set; otherwise the value passes unchanged and count
// bit K is cleared.
//   value_in  / value_out  working value
//   count_in  / count_out  partial zero count
module lzc_norm_level
  import fpu_lzc_pkg::*;
#(
  parameter  int XLEN = 64,
  parameter  int K    = 0,
  localparam int XLOG = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] value_in,
  input  logic [XLOG-1:0] count_in,
  output logic [XLEN-1:0] value_out,
  output logic [XLOG-1:0] count_out
);

  localparam int SPAN = 1 << K;

  logic top_zero;

  assign top_zero = (value_in[XLEN-1 -: SPAN] == '0);

  always_comb begin
    value_out    = top_zero ? (value_in << SPAN) : value_in;
    count_out    = count_in;
    count_out[K] = top_zero;
  end

endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: pipelined leading/trailing-zero counter with normaliser.
//   clock, reset (synchronous, active-low)
//   in_valid/in_ready/in_data/in_mode/in_tag     input beat
//   out_valid/out_ready                          output handshake
//   out_count  zero count (XLEN-1 for an all-zero operand)
//   out_zero   operand was all zeros
//   out_norm   mode 0: shifted left until MSB set; mode 1: shifted right
//              until LSB set
//   out_mode, out_tag  echoed with their beat
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holding valid=1 without ready keeps its beat; out_* are held
// stable while out_valid=1 and out_ready=0. ready never looks at valid.
//
// The XLOG shift levels are grouped into STAGES register stages. Each stage
// has its own valid bit and loads when empty or when the next stage loads,
// so bubbles collapse and a full pipe still moves one beat per cycle.
// Mode 1 reverses the operand on entry and the normalised value in the last
// stage, turning the leading-zero datapath into a trailing-zero one.
module lzc_norm_pipe
  import fpu_lzc_pkg::*;
#(
  parameter  int XLEN   = 64,
  parameter  int STAGES = 2,
  localparam int XLOG   = $clog2(XLEN)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  input  logic             in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLOG-1:0]  out_count,
  output logic             out_zero,
  output logic [XLEN-1:0]  out_norm,
  output logic             out_mode,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] x);
    logic [MAX_XLEN-1:0] r;
    r = bit_reverse(MAX_XLEN'(x) << (MAX_XLEN - XLEN));
    return r[XLEN-1:0];
  endfunction

  // Per-stage register outputs, gathered so the next stage can read them.
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] zero_q;
  logic [STAGES-1:0] mode_q;
  logic [XLEN-1:0]   norm_q  [STAGES];
  logic [XLOG-1:0]   count_q [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];

  // load[s]: stage s captures on the next edge. load[STAGES] is the sink.
  logic [STAGES:0] load;

  always_comb begin
    load         = '0;
    load[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      load[s] = !valid_q[s] || load[s+1];
    end
  end

  assign in_ready = load[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int FIRST = stage_first_level(s, XLOG, STAGES);
    localparam int NLEV  = levels_in_stage(s, XLOG, STAGES);

    logic [XLEN-1:0]  src_val;
    logic [XLOG-1:0]  src_cnt;
    logic             src_valid;
    logic             src_zero;
    logic             src_mode;
    logic [TAG_W-1:0] src_tag;

    if (s == 0) begin : g_src
      assign src_val   = in_mode ? rev(in_data) : in_data;
      assign src_cnt   = '0;
      assign src_valid = in_valid;
      assign src_zero  = (in_data == '0);
      assign src_mode  = in_mode;
      assign src_tag   = in_tag;
    end else begin : g_src
      assign src_val   = norm_q[s-1];
      assign src_cnt   = count_q[s-1];
      assign src_valid = valid_q[s-1];
      assign src_zero  = zero_q[s-1];
      assign src_mode  = mode_q[s-1];
      assign src_tag   = tag_q[s-1];
    end

    for (genvar l = 0; l < NLEV; l++) begin : g_level
      logic [XLEN-1:0] v_in;
      logic [XLEN-1:0] v_out;
      logic [XLOG-1:0] c_in;
      logic [XLOG-1:0] c_out;

      if (l == 0) begin : g_first
        assign v_in = src_val;
        assign c_in = src_cnt;
      end else begin : g_chain
        assign v_in = g_level[l-1].v_out;
        assign c_in = g_level[l-1].c_out;
      end

      lzc_norm_level #(
        .XLEN (XLEN),
        .K    (XLOG - 1 - FIRST - l)
      ) u_level (
        .value_in  (v_in),
        .count_in  (c_in),
        .value_out (v_out),
        .count_out (c_out)
      );
    end

    logic [XLEN-1:0] lvl_val;
    logic [XLOG-1:0] lvl_cnt;
    logic [XLEN-1:0] norm_d;

    assign lvl_val = g_level[NLEV-1].v_out;
    assign lvl_cnt = g_level[NLEV-1].c_out;

    // The last stage undoes the entry reversal so mode 1 leaves right-aligned.
    if (s == STAGES - 1) begin : g_exit
      assign norm_d = src_mode ? rev(lvl_val) : lvl_val;
    end else begin : g_pass
      assign norm_d = lvl_val;
    end

    logic             valid_r;
    logic             zero_r;
    logic             mode_r;
    logic [XLEN-1:0]  norm_r;
    logic [XLOG-1:0]  count_r;
    logic [TAG_W-1:0] tag_r;

    // Data registers are cleared as well so the outputs read 0 after reset.
    always_ff @(posedge clock) begin
      if (!reset) begin
        valid_r <= 1'b0;
        zero_r  <= 1'b0;
        mode_r  <= 1'b0;
        norm_r  <= '0;
        count_r <= '0;
        tag_r   <= '0;
      end else if (load[s]) begin
        valid_r <= src_valid;
        zero_r  <= src_zero;
        mode_r  <= src_mode;
        norm_r  <= norm_d;
        count_r <= lvl_cnt;
        tag_r   <= src_tag;
      end
    end

    assign valid_q[s] = valid_r;
    assign zero_q[s]  = zero_r;
    assign mode_q[s]  = mode_r;
    assign norm_q[s]  = norm_r;
    assign count_q[s] = count_r;
    assign tag_q[s]   = tag_r;
  end

  assign out_valid = valid_q[STAGES-1];
  assign out_zero  = zero_q[STAGES-1];
  assign out_mode  = mode_q[STAGES-1];
  assign out_norm  = norm_q[STAGES-1];
  assign out_count = count_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Testbench for lzc_norm_pipe: a 32-bit, 3-stage instance for mode 1,
// mixed patterns, all-zero, backpressure, random and reset scenarios, and a
// 256-bit, 3-stage instance for the mode 0 walking-one stream.
module tb_lzc_norm_pipe;

  localparam int W   = 32;
  localparam int S   = 3;
  localparam int WL  = $clog2(W);
  localparam int WW  = 256;
  localparam int WS  = 3;
  localparam int WWL = $clog2(WW);
  localparam int EW  = W + WL + 10;  // {norm, count, zero, mode, tag}

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- main instance ----------------
  logic          in_valid, in_ready, in_mode;
  logic [W-1:0]  in_data;
  logic [7:0]    in_tag;
  logic          out_valid, out_ready, out_zero, out_mode;
  logic [WL-1:0] out_count;
  logic [W-1:0]  out_norm;
  logic [7:0]    out_tag;

  lzc_norm_pipe #(.XLEN(W), .STAGES(S)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_norm  (out_norm),
    .out_mode  (out_mode),
    .out_tag   (out_tag)
  );

  // ---------------- wide instance ----------------
  logic           w_in_valid, w_in_ready, w_in_mode;
  logic [WW-1:0]  w_in_data;
  logic [7:0]     w_in_tag;
  logic           w_out_valid, w_out_ready, w_out_zero, w_out_mode;
  logic [WWL-1:0] w_out_count;
  logic [WW-1:0]  w_out_norm;
  logic [7:0]     w_out_tag;

  lzc_norm_pipe #(.XLEN(WW), .STAGES(WS)) u_wide (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_data   (w_in_data),
    .in_mode   (w_in_mode),
    .in_tag    (w_in_tag),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_count (w_out_count),
    .out_zero  (w_out_zero),
    .out_norm  (w_out_norm),
    .out_mode  (w_out_mode),
    .out_tag   (w_out_tag)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act;
  assign act = {out_norm, out_count, out_zero, out_mode, out_tag};

  // Reference: count zeros by scanning, normalise with a plain shift.
  function automatic logic [EW-1:0] model(input logic [W-1:0] d, input logic m,
                                          input logic [7:0] t);
    int n;
    logic [W-1:0] nv;
    n = 0;
    if (d == '0) return {{W{1'b0}}, WL'(W - 1), 1'b1, m, t};
    if (!m) begin
      while (d[W-1-n] == 1'b0) n++;
      nv = d << n;
    end else begin
      while (d[n] == 1'b0) n++;
      nv = d >> n;
    end
    return {nv, WL'(n), 1'b0, m, t};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_in_mode = 1'b0; w_in_tag = '0; w_out_ready = 1'b1;
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid act=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_out_count act=%0d exp=0", out_count); end
    checks++; if (out_norm !== '0) begin errors++; $display("FAIL reset_out_norm act=%h exp=0", out_norm); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag act=%h exp=0", out_tag); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero act=%b exp=0", out_zero); end
    checks++; if (w_out_valid !== 1'b0 || w_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wide act=%b%b exp=01", w_out_valid, w_in_ready);
    end
    step();
  endtask

  task automatic test_walk_wide();
    int sent = 0, got = 0, cyc = 0, first_in = -1, first_out = -1, last_out = -1;
    logic [WW-1:0] top1;
    top1 = '0;
    top1[WW-1] = 1'b1;
    w_out_ready = 1'b1;
    w_in_mode = 1'b0;
    while (got < WW && cyc < WW + 50) begin
      w_in_valid = (sent < WW);
      w_in_data = WW'(1) << sent;
      w_in_tag = 8'(sent);
      @(negedge clock);
      if (w_out_valid && w_out_ready) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        checks++;
        if (w_out_count !== WWL'(WW - 1 - got) || w_out_norm !== top1 || w_out_zero !== 1'b0 ||
            w_out_tag !== 8'(got)) begin
          errors++;
          $display("FAIL wide_walk j=%0d count act=%0d exp=%0d norm_ok=%b zero act=%b exp=0 tag act=%0d",
                   got, w_out_count, WW - 1 - got, (w_out_norm === top1), w_out_zero, w_out_tag);
        end
        got++;
      end
      if (w_in_valid && w_in_ready) begin
        if (first_in < 0) first_in = cyc;
        sent++;
      end
      step();
      cyc++;
    end
    w_in_valid = 1'b0;
    checks++; if (got != WW) begin errors++; $display("FAIL wide_walk_count act=%0d exp=%0d", got, WW); end
    checks++; if (first_out - first_in != WS) begin
      errors++; $display("FAIL wide_latency act=%0d exp=%0d", first_out - first_in, WS);
    end
    checks++; if (last_out - first_out != WW - 1) begin
      errors++; $display("FAIL wide_throughput act=%0d exp=%0d", last_out - first_out, WW - 1);
    end
  endtask

  task automatic test_walk_mode1();
    int sent = 0, got = 0, cyc = 0;
    out_ready = 1'b1;
    in_mode = 1'b1;
    while (got < W && cyc < W + 40) begin
      in_valid = (sent < W);
      in_data = W'(1) << sent;
      in_tag = 8'(sent);
      @(negedge clock);
      if (out_valid && out_ready) begin
        checks++;
        if (out_count !== WL'(got) || out_norm !== W'(1) || out_zero !== 1'b0 ||
            out_mode !== 1'b1 || out_tag !== 8'(got)) begin
          errors++;
          $display("FAIL walk_mode1 j=%0d act count=%0d norm=%h zero=%b tag=%0d exp count=%0d norm=1 zero=0",
                   got, out_count, out_norm, out_zero, out_tag, got);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != W) begin errors++; $display("FAIL walk_mode1_count act=%0d exp=%0d", got, W); end
  endtask

  task automatic test_mixed();
    logic [W-1:0]  t_data  [8];
    logic          t_mode  [8];
    logic [WL-1:0] t_count [8];
    logic [W-1:0]  t_norm  [8];
    logic          t_zero  [8];
    int sent = 0, got = 0, cyc = 0;
    t_data  = '{32'h00F0_0000, 32'h00F0_0000, 32'h0, 32'h0,
                32'h8000_0001, 32'h8000_0001, 32'h0000_0100, 32'h0000_0100};
    t_mode  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t_count = '{5'd8, 5'd20, 5'd31, 5'd31, 5'd0, 5'd0, 5'd23, 5'd8};
    t_norm  = '{32'hF000_0000, 32'h0000_000F, 32'h0, 32'h0,
                32'h8000_0001, 32'h8000_0001, 32'h8000_0000, 32'h0000_0001};
    t_zero  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    while (got < 8 && cyc < 40) begin
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_data = t_data[sent];
        in_mode = t_mode[sent];
        in_tag = 8'(sent);
      end
      @(negedge clock);
      if (out_valid && out_ready) begin
        checks++;
        if (out_count !== t_count[got] || out_norm !== t_norm[got] || out_zero !== t_zero[got] ||
            out_mode !== t_mode[got] || out_tag !== 8'(got)) begin
          errors++;
          $display("FAIL mixed[%0d] act count=%0d norm=%h zero=%b exp count=%0d norm=%h zero=%b",
                   got, out_count, out_norm, out_zero, t_count[got], t_norm[got], t_zero[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL mixed_count act=%0d exp=8", got); end
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0, cyc = 0;
    logic pending = 1'b0, stalled = 1'b0;
    logic [EW-1:0] held, e;
    held = '0;
    exp_q.delete();
    while (got < 10 && cyc < 400) begin
      if (!pending) begin
        in_data = $urandom() >> $urandom_range(0, W - 1);
        if ($urandom_range(0, 7) == 0) in_data = '0;
        in_mode = 1'($urandom_range(0, 1));
        in_tag = 8'(sent);
      end
      in_valid = (sent < 10);
      out_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      @(negedge clock);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || act !== held) begin
          errors++; $display("FAIL stall_hold act=%h exp=%h valid=%b", act, held, out_valid);
        end
      end
      if (cyc == S) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready act=%b exp=0", in_ready); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra act=%h exp=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin errors++; $display("FAIL bp_beat act=%h exp=%h", act, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_mode, in_tag));
        sent++;
        pending = 1'b0;
      end else begin
        pending = in_valid;
      end
      stalled = out_valid && !out_ready;
      held = act;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 10 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_delivered act=%0d left=%0d exp=10 left=0", got, exp_q.size());
    end
  endtask

  task automatic test_random();
    int sent = 0, got = 0, cyc = 0;
    logic pending = 1'b0;
    logic [EW-1:0] e;
    exp_q.delete();
    while (got < 300 && cyc < 3000) begin
      if (!pending) begin
        in_data = $urandom() >> $urandom_range(0, W - 1);
        if ($urandom_range(0, 15) == 0) in_data = '0;
        in_mode = 1'($urandom_range(0, 1));
        in_tag = 8'($urandom_range(0, 255));
      end
      in_valid = (sent < 300) && (pending || ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra act=%h exp=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin errors++; $display("FAIL rand_beat n=%0d act=%h exp=%h", got, act, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, in_mode, in_tag));
        sent++;
        pending = 1'b0;
      end else begin
        pending = in_valid;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 300 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_delivered act=%0d left=%0d exp=300 left=0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int leaked = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < S; i++) begin
      in_data = $urandom();
      in_mode = 1'b0;
      in_tag = 8'(100 + i);
      step();
    end
    in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_full act valid=%b ready=%b exp valid=1 ready=0", out_valid, in_ready);
    end
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid act=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready act=%b exp=1", in_ready); end
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) leaked++;
      step();
    end
    checks++; if (leaked != 0) begin errors++; $display("FAIL mid_stale act=%0d exp=0", leaked); end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_walk_wide();
    test_walk_mode1();
    test_mixed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading/trailing-zero counter with an integrated normaliser.
- Generalises the fixed-width combinational lzc_N family to any power-of-two width and a configurable pipeline depth.
- Adds a trailing-zero mode and a valid/ready handshake with backpressure.
- Sits in the FPU datapath after add/sub and fused multiply-add, ahead of rounding, where the mantissa is normalised and the exponent adjust is needed.

Parameters:
- XLEN, 64, datapath width; power of two, 4..256.
- XLOG, $clog2(XLEN), count width; derived, not overridden.
- STAGES, 2, register stages; 1..XLOG; the XLOG shift levels are split evenly across stages, with extra levels going to the earliest stages.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  XLEN  operand.
- in_mode  in  1  0 = leading-zero count and left normalise; 1 = trailing-zero count and right normalise.
- in_tag  in  8  opaque sideband, passed through aligned with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_count  out  XLOG  zero count.
- out_zero  out  1  operand was all zeros.
- out_norm  out  XLEN  normalised operand.
- out_mode  out  1  echoed mode.
- out_tag  out  8  echoed tag.

Behaviour:
- Reset is sampled on the clock edge while reset==0:
  - all stage valid bits are cleared, so out_valid=0;
  - out_count, out_norm, out_tag and out_zero are 0;
  - in_ready is 1 in the first cycle after reset deasserts;
  - data registers need no reset, but the observable outputs listed above must read 0 after reset.
- Any beat in flight when reset asserts is discarded. No output is produced for it.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_* must hold stable.
- Algorithm, in shift levels k = XLOG-1 down to 0:
  - If the top 2^k bits of the working value are all zero, shift left by 2^k and set count bit k.
  - Otherwise pass the value unchanged and clear count bit k.
- Mode 1: in_data is bit-reversed on entry; the final normalised value is bit-reversed on exit. out_norm is therefore in_data shifted right by the trailing-zero count.
- All-zero operand: out_zero=1, out_count = XLEN-1 (all ones), out_norm = 0. This applies in both modes.
- Non-zero operand:
  - out_zero=0;
  - mode 0: out_norm[XLEN-1]=1;
  - mode 1: out_norm[0]=1.
- Latency: exactly STAGES cycles from input transfer to out_valid, when there is no backpressure.
- Throughput: one beat per cycle when out_ready=1.
- Per-stage valid bit; stage i loads when it is empty or stage i+1 loads in the same cycle. Bubbles therefore collapse.
- in_ready = !valid[0] || load[1]. For the last stage, its load term is out_ready.
- in_ready must not combinationally depend on in_valid.
- Simultaneous input and output transfer with the pipe full: both occur, and occupancy stays STAGES.
- Beats leave in order. in_mode and in_tag travel with their beat.

Decomposition:
- Shared package fpu_lzc_pkg holds:
  - function bit_reverse(XLEN);
  - localparam helper levels_in_stage(i, XLOG, STAGES);
  - typedef lzc_beat_t {norm, count, zero, mode, tag}, parameterised through package constants for the default XLEN.
- One sub-module, lzc_norm_level: purely combinational, one shift level, with parameters XLEN and K, inputs value/count, outputs value/count.
- The top module instantiates XLOG levels via generate, with registers placed at stage boundaries.

Test Plan:
- Walking one, mode 0, XLEN=256, STAGES=3:
  - stimulus: in_data = 1<<j for j = 0..255, back-to-back, out_ready=1;
  - response: out_count = 255-j, out_norm = 1<<255, out_zero=0;
  - first result 3 cycles after the first input transfer; one result per cycle after that.
- Walking one, mode 1, XLEN=64:
  - stimulus: in_data = 1<<j;
  - response: out_count = j, out_norm = 1.
- Mixed patterns, XLEN=32:
  - 0x00F0_0000 in mode 0 -> count 8, norm 0xF000_0000;
  - 0x00F0_0000 in mode 1 -> count 20, norm 0x0000_000F.
- All-zero, XLEN=16:
  - stimulus: in_data = 0, in either mode;
  - response: out_zero=1, out_count = 15, out_norm = 0.
- Backpressure:
  - stimulus: stream 10 tagged beats (tag 0..9) with out_ready toggled pseudo-randomly;
  - response: out_* stay stable while stalled; in_ready drops once all STAGES stages are full;
  - all 10 results arrive in tag order, none lost or duplicated.
- Reset mid-operation:
  - stimulus: pipe full, reset=0 for one cycle;
  - response: out_valid=0 and in_ready=1 on the next cycle; no stale beat is ever emitted.
